// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA scan-out of a 1bpp framebuffer (16 pixels per word), FG/BG mapped to RGB332.
// Define VGA_FRAME_TICK_EN to add the FRAME_TICK output (one-cycle strobe at start of vblank).
module vga_scan_ctrl #(
    parameter int CLK_DIV       = 2,
    parameter int H_VIS         = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_VIS         = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int WORDS_PER_ROW = 40
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] DATA_OUT_VGA,
    output logic [15:0] RADDR_VGA,
    input  logic [7:0]  FG_COLOR,
    input  logic [7:0]  BG_COLOR,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [2:0]  RED,
    output logic [2:0]  GREEN,
    output logic [1:0]  BLUE
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic        FRAME_TICK
`endif
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int COL_W   = HC_W - 4;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]  HC_VIS      = HC_W'(H_VIS);
    localparam logic [HC_W-1:0]  HC_HS_START = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0]  HC_HS_END   = HC_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [VC_W-1:0]  VC_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]  VC_VIS      = VC_W'(V_VIS);
    localparam logic [VC_W-1:0]  VC_VIS_LAST = VC_W'(V_VIS - 1);
    localparam logic [VC_W-1:0]  VC_VS_START = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0]  VC_VS_END   = VC_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [15:0]      ROW_STEP    = 16'(WORDS_PER_ROW);

    logic [DIV_W-1:0] div_reg;
    logic [HC_W-1:0]  hc_reg, hc_next;
    logic [VC_W-1:0]  vc_reg, vc_next;
    logic [15:0]      row_base_reg, row_base_next;
    logic [15:0]      shift_reg, shift_next;
    logic [15:0]      raddr_reg, raddr_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic [7:0]       rgb_reg, rgb_next;
    logic [COL_W-1:0] col_next;
    logic [15:0]      word_cur;
    logic [7:0]       colour_sel;
    logic             tick, line_end, frame_end, visible, pix_bit;

    assign tick = (div_reg == DIV_LAST);

    always_comb begin
        line_end      = (hc_reg == HC_LAST);
        frame_end     = (vc_reg == VC_LAST);
        hc_next       = line_end ? '0 : hc_reg + HC_W'(1);
        vc_next       = vc_reg;
        row_base_next = row_base_reg;
        if (line_end) begin
            if (frame_end) begin
                vc_next       = '0;
                row_base_next = '0;
            end else begin
                vc_next = vc_reg + VC_W'(1);
                // Advance one framebuffer row per pair of scanlines; frozen through vblank
                // so the address stays inside the framebuffer.
                if (vc_reg[0] && (vc_reg < VC_VIS_LAST)) begin
                    row_base_next = row_base_reg + ROW_STEP;
                end
            end
        end

        col_next   = (hc_next < HC_VIS) ? hc_next[HC_W-1:4] : COL_LAST;
        raddr_next = row_base_next + 16'(col_next);

        visible  = (hc_reg < HC_VIS) && (vc_reg < VC_VIS);
        // Memory data is valid for the current hc; the first pixel of a word bypasses the shifter.
        word_cur = (hc_reg[3:0] == 4'd0) ? DATA_OUT_VGA : shift_reg;
        pix_bit  = word_cur[15];
        shift_next = visible ? {word_cur[14:0], 1'b0} : shift_reg;

        rgb_next   = visible ? colour_sel : 8'h00;
        hsync_next = !((hc_reg >= HC_HS_START) && (hc_reg < HC_HS_END));
        vsync_next = !((vc_reg >= VC_VS_START) && (vc_reg < VC_VS_END));
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_colour
            assign colour_sel[gi] = pix_bit ? FG_COLOR[gi] : BG_COLOR[gi];
        end
    endgenerate

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_reg;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_reg      <= '0;
            hc_reg       <= '0;
            vc_reg       <= '0;
            row_base_reg <= '0;
            shift_reg    <= '0;
            raddr_reg    <= '0;
            hsync_reg    <= 1'b1;
            vsync_reg    <= 1'b1;
            rgb_reg      <= '0;
`ifdef VGA_FRAME_TICK_EN
            frame_tick_reg <= 1'b0;
`endif
        end else begin
            div_reg <= tick ? '0 : div_reg + DIV_W'(1);
            if (tick) begin
                hc_reg       <= hc_next;
                vc_reg       <= vc_next;
                row_base_reg <= row_base_next;
                shift_reg    <= shift_next;
                raddr_reg    <= raddr_next;
                hsync_reg    <= hsync_next;
                vsync_reg    <= vsync_next;
                rgb_reg      <= rgb_next;
            end
`ifdef VGA_FRAME_TICK_EN
            frame_tick_reg <= tick && line_end && (vc_reg == VC_VIS_LAST);
`endif
        end
    end

    assign RADDR_VGA = raddr_reg;
    assign HSYNC     = hsync_reg;
    assign VSYNC     = vsync_reg;
    assign RED       = rgb_reg[7:5];
    assign GREEN     = rgb_reg[4:2];
    assign BLUE      = rgb_reg[1:0];
`ifdef VGA_FRAME_TICK_EN
    assign FRAME_TICK = frame_tick_reg;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full-size instance checked against a vector table,
// reduced-geometry instance checked tick by tick against a positional reference model.
module tb_vga_scan_ctrl;

    localparam int B_HV = 64, B_HFP = 4, B_HS = 8, B_HBP = 4;
    localparam int B_VV = 16, B_VFP = 2, B_VS = 2, B_VBP = 3, B_W = 4;
    localparam int B_HT = B_HV + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VV + B_VFP + B_VS + B_VBP;
    localparam int B_FRAME = B_HT * B_VT;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, rst_n_b;
    logic [15:0] data_a, data_b, raddr_a, raddr_b;
    logic [7:0]  fg_a, bg_a, fg_b, bg_b;
    logic        hs_a, vs_a, hs_b, vs_b;
    logic [2:0]  r_a, g_a, r_b, g_b;
    logic [1:0]  b_a, b_b;
`ifdef VGA_FRAME_TICK_EN
    logic        ft_a, ft_b;
`endif

    logic [15:0] mem_a [0:9599];
    logic [15:0] mem_b [0:31];

    assign data_a = (raddr_a < 16'd9600) ? mem_a[raddr_a] : 16'h0000;
    assign data_b = (raddr_b < 16'd32) ? mem_b[raddr_b[4:0]] : 16'h0000;

    vga_scan_ctrl dut_a (
        .CLK(clk), .RST_N(rst_n_a), .DATA_OUT_VGA(data_a), .RADDR_VGA(raddr_a),
        .FG_COLOR(fg_a), .BG_COLOR(bg_a), .HSYNC(hs_a), .VSYNC(vs_a),
        .RED(r_a), .GREEN(g_a), .BLUE(b_a)
`ifdef VGA_FRAME_TICK_EN
        , .FRAME_TICK(ft_a)
`endif
    );

    vga_scan_ctrl #(
        .CLK_DIV(1), .H_VIS(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_VIS(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .WORDS_PER_ROW(B_W)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n_b), .DATA_OUT_VGA(data_b), .RADDR_VGA(raddr_b),
        .FG_COLOR(fg_b), .BG_COLOR(bg_b), .HSYNC(hs_b), .VSYNC(vs_b),
        .RED(r_b), .GREEN(g_b), .BLUE(b_b)
`ifdef VGA_FRAME_TICK_EN
        , .FRAME_TICK(ft_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          t;
        logic        hs;
        logic        vs;
        logic [7:0]  rgb;
        logic [15:0] raddr;
    } vec_t;

    function automatic vec_t mk(input int t, input logic hs, input logic vs,
                                input logic [7:0] rgb, input logic [15:0] ra);
        vec_t v;
        v.t = t; v.hs = hs; v.vs = vs; v.rgb = rgb; v.raddr = ra;
        return v;
    endfunction

    // After tick t the pixel/sync outputs describe scan position t-1 and the
    // address describes scan position t (positions counted from reset release).
    function automatic logic [26:0] model_b(input int t, input logic [7:0] fg, input logic [7:0] bg);
        int hc, vc, phc, pvc, p;
        logic hs, vs, ft;
        logic [7:0] rgb;
        logic [15:0] ra, w;
        hc = t % B_HT;
        vc = (t / B_HT) % B_VT;
        ra = 16'((((vc < B_VV) ? vc : B_VV - 1) / 2) * B_W + ((hc < B_HV) ? hc / 16 : B_W - 1));
        hs = 1'b1; vs = 1'b1; rgb = 8'h00; ft = 1'b0;
        if (t > 0) begin
            p   = t - 1;
            phc = p % B_HT;
            pvc = (p / B_HT) % B_VT;
            hs  = !(phc >= B_HV + B_HFP && phc < B_HV + B_HFP + B_HS);
            vs  = !(pvc >= B_VV + B_VFP && pvc < B_VV + B_VFP + B_VS);
            if (phc < B_HV && pvc < B_VV) begin
                w   = mem_b[(pvc / 2) * B_W + phc / 16];
                rgb = w[15 - (phc % 16)] ? fg : bg;
            end
            ft = (phc == B_HT - 1) && (pvc == B_VV - 1);
        end
        return {ft, hs, vs, rgb, ra};
    endfunction

    int          t_b = 0;
    int          blank_nz = 0;
    int          vs_low = 0;
    logic [15:0] max_ra = 16'h0;

    task automatic run_b(input int until_t);
        logic [7:0]  fgs, bgs;
        logic [26:0] e, a;
        int p, phc, pvc;
        while (t_b < until_t) begin
            fg_b = 8'($urandom);
            bg_b = 8'($urandom);
            fgs  = fg_b;
            bgs  = bg_b;
            @(posedge clk);
            t_b++;
            @(negedge clk);
            e = model_b(t_b, fgs, bgs);
`ifdef VGA_FRAME_TICK_EN
            a = {ft_b, hs_b, vs_b, r_b, g_b, b_b, raddr_b};
`else
            a = {1'b0, hs_b, vs_b, r_b, g_b, b_b, raddr_b};
            e[26] = 1'b0;
`endif
            check($sformatf("scan t=%0d", t_b), 64'(a), 64'(e));
            p   = t_b - 1;
            phc = p % B_HT;
            pvc = (p / B_HT) % B_VT;
            if (!(phc < B_HV && pvc < B_VV) && ({r_b, g_b, b_b} != 8'h00)) blank_nz++;
            if (raddr_b > max_ra) max_ra = raddr_b;
            if (t_b > B_FRAME && t_b <= 2 * B_FRAME && !vs_b) vs_low++;
        end
    endtask

    vec_t vecs [20];
    int   cyc_a;

    initial begin
        vecs[0]  = mk(1,    1, 1, 8'hFF, 16'd0);
        vecs[1]  = mk(2,    1, 1, 8'h03, 16'd0);
        vecs[2]  = mk(15,   1, 1, 8'h03, 16'd0);
        vecs[3]  = mk(16,   1, 1, 8'hFF, 16'd1);
        vecs[4]  = mk(17,   1, 1, 8'h03, 16'd1);
        vecs[5]  = mk(640,  1, 1, 8'h03, 16'd39);
        vecs[6]  = mk(641,  1, 1, 8'h00, 16'd39);
        vecs[7]  = mk(656,  1, 1, 8'h00, 16'd39);
        vecs[8]  = mk(657,  0, 1, 8'h00, 16'd39);
        vecs[9]  = mk(752,  0, 1, 8'h00, 16'd39);
        vecs[10] = mk(753,  1, 1, 8'h00, 16'd39);
        vecs[11] = mk(800,  1, 1, 8'h00, 16'd0);
        vecs[12] = mk(801,  1, 1, 8'hFF, 16'd0);
        vecs[13] = mk(802,  1, 1, 8'h03, 16'd0);
        vecs[14] = mk(816,  1, 1, 8'hFF, 16'd1);
        vecs[15] = mk(1456, 1, 1, 8'h00, 16'd39);
        vecs[16] = mk(1457, 0, 1, 8'h00, 16'd39);
        vecs[17] = mk(1600, 1, 1, 8'h00, 16'd40);
        vecs[18] = mk(1601, 1, 1, 8'h03, 16'd40);
        vecs[19] = mk(1616, 1, 1, 8'h03, 16'd41);

        for (int i = 0; i < 9600; i++) mem_a[i] = 16'h0000;
        mem_a[0] = 16'h8001;
        for (int i = 0; i < 32; i++) mem_b[i] = 16'($urandom);
        fg_a = 8'hFF; bg_a = 8'h03;
        fg_b = 8'h00; bg_b = 8'h00;
        rst_n_a = 1'b0; rst_n_b = 1'b0;

        repeat (3) @(negedge clk);
        check("reset a", 64'({hs_a, vs_a, r_a, g_a, b_a, raddr_a}), 64'({1'b1, 1'b1, 8'h00, 16'h0000}));
        check("reset b", 64'({hs_b, vs_b, r_b, g_b, b_b, raddr_b}), 64'({1'b1, 1'b1, 8'h00, 16'h0000}));

        // Full-size geometry, CLK_DIV=2: tick t lands on the 2t-th posedge after release.
        rst_n_a = 1'b1;
        cyc_a   = 0;
        for (int k = 0; k < 20; k++) begin
            while (cyc_a < 2 * vecs[k].t) begin
                @(posedge clk);
                cyc_a++;
            end
            @(negedge clk);
            check($sformatf("vec t=%0d", vecs[k].t),
                  64'({hs_a, vs_a, r_a, g_a, b_a, raddr_a}),
                  64'({vecs[k].hs, vecs[k].vs, vecs[k].rgb, vecs[k].raddr}));
            $display("vec t=%0d hs=%0b vs=%0b rgb=%h raddr=%0d", vecs[k].t, hs_a, vs_a,
                     {r_a, g_a, b_a}, raddr_a);
        end
        rst_n_a = 1'b0;

        // Reduced geometry, CLK_DIV=1: random memory and colours against the model.
        @(negedge clk);
        rst_n_b = 1'b1;
        t_b = 0;
        run_b(B_FRAME + B_VV * B_HT + 10);
        $display("frame 1 scanned, t=%0d", t_b);

        // Switch to all-ones memory during vblank so only blanking can produce black.
        for (int i = 0; i < 32; i++) mem_b[i] = 16'hFFFF;
        run_b(2 * B_FRAME + 10 * B_HT + 20);
        $display("frame 2 scanned, t=%0d", t_b);
        check("vsync low ticks", 64'(vs_low), 64'(B_VS * B_HT));
        check("max raddr", 64'(max_ra), 64'(B_W * B_VV / 2 - 1));

        // Mid-frame reset: outputs drop to reset values at once, scan restarts at (0,0).
        rst_n_b = 1'b0;
        #1;
        check("midreset now", 64'({hs_b, vs_b, r_b, g_b, b_b, raddr_b}), 64'({1'b1, 1'b1, 8'h00, 16'h0000}));
        repeat (3) @(negedge clk);
        check("midreset hold", 64'({hs_b, vs_b, r_b, g_b, b_b, raddr_b}), 64'({1'b1, 1'b1, 8'h00, 16'h0000}));
        $display("mid-frame reset applied");
        rst_n_b = 1'b1;
        t_b = 0;
        run_b(B_FRAME + 50);
        $display("frame after reset scanned, t=%0d", t_b);
        check("blank pixels nonzero", 64'(blank_nz), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
